ts_packet_mux: RTL and testbench
================================

Name: ts_packet_mux

Overview:
- N-channel transport-stream packet multiplexer, the parametrised successor of the 4-channel source switch.
- Sits between the per-channel input packet FIFOs and the downstream byte-stream path.
- Selects channels that hold a full packet using round-robin over enabled channels. For each selected packet it emits HDR_LEN header bytes from a synchronous header ROM, then PKT_LEN payload bytes.
- Adds downstream valid/ready backpressure, a per-channel enable mask and single-cycle arbitration.

Parameters:
- N_CH, 4: number of source channels (2..16).
- PKT_LEN, 188: payload bytes read per packet.
- HDR_LEN, 4: header bytes prepended per packet; 0 means no header phase.
- HA_W, 4: header address width; must satisfy 2^HA_W >= N_CH*HDR_LEN.

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- GOT_FULL_PACKET  in  N_CH  per-channel flag: FIFO holds at least one full packet.
- CH_EN  in  N_CH  per-channel enable mask.
- DATA_IN_BUS  in  8*N_CH  FIFO read data; channel i occupies bits [8i+7:8i]. Valid 1 cycle after RD_REQ[i].
- RD_REQ  out  N_CH  one-hot FIFO read strobe.
- HEADER_BYTE_ADDR  out  HA_W  equals ch*HDR_LEN + hdr_idx.
- HEADER_BYTE  in  8  ROM data, valid 1 cycle after address.
- DATA_OUT  out  8  output byte.
- D_VALID_OUT  out  1  DATA_OUT valid.
- READY_IN  in  1  downstream accepts the byte when D_VALID_OUT && READY_IN.
- P_SYNC_OUT  out  1  high with the first payload byte of each packet.
- STATE_MON  out  2  current FSM state encoding.
- CUR_CH  out  4  channel being served.
- SYNC_ERR  out  1  sync-byte error pulse (see Optional Feature).
- ERR_COUNT  out  16  saturating sync-error count.

Behaviour:
- Reset (RST=1 at an edge):
  - State CHECK; RR pointer and CUR_CH = 0.
  - RD_REQ, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR = 0; DATA_OUT = 0x00; ERR_COUNT = 0.
  - Output buffer emptied. In-flight data is discarded.
  - Reset mid-packet aborts the packet; upstream FIFO realignment is the upstream block's responsibility.
- FSM states: CHECK=0, HEADER=1, PAYLOAD=2.
- CHECK:
  - Candidate set = GOT_FULL_PACKET & CH_EN.
  - Grant the lowest index >= RR pointer, wrapping modulo N_CH, in one cycle.
  - No candidate: stay in CHECK.
  - Grant: latch CUR_CH, reset byte counter, go to HEADER (or PAYLOAD if HDR_LEN=0).
- Read issue:
  - A "read" is either a ROM address issue (HEADER) or an RD_REQ[CUR_CH] pulse (PAYLOAD).
  - Data lands 1 cycle later in a 2-entry output buffer; each entry carries a sync tag.
  - A read may issue only when buffer occupancy + reads in flight < 2.
  - With READY_IN held high, throughput is 1 byte/cycle.
- HEADER: issue HDR_LEN reads with hdr_idx 0..HDR_LEN-1, then go to PAYLOAD.
- PAYLOAD:
  - Issue PKT_LEN RD_REQ pulses; the first carries sync tag 1.
  - After the last issue: RR pointer = CUR_CH+1 mod N_CH, go to CHECK.
  - The buffer drains concurrently, so the next packet's header may follow without gaps.
- Output side:
  - DATA_OUT, D_VALID_OUT and P_SYNC_OUT come from the buffer head.
  - They stay stable while D_VALID_OUT && !READY_IN.
- Byte counter width: clog2(max(HDR_LEN, PKT_LEN)+1); it never wraps inside a packet.
- Once granted, a packet always completes. CH_EN or GOT_FULL_PACKET changes take effect only at the next CHECK.
- READY_IN low for any duration: no byte loss, no duplication, and RD_REQ stays low while credits are exhausted.
- Latency: grant to first D_VALID_OUT = 2 cycles when READY_IN=1.

Optional Feature:
- Macro: TS_SYNC_CHECK_EN.
- Defined:
  - When the tagged first payload byte is accepted and DATA_OUT != 0x47, SYNC_ERR pulses 1 cycle with that byte.
  - ERR_COUNT increments and saturates at 0xFFFF.
  - Packet forwarding is unaffected.
- Undefined: SYNC_ERR and ERR_COUNT are tied to 0; no compare logic.

Test Plan:
- Single channel: N_CH=4, ch2 full, CH_EN=4'hF, READY_IN=1, ROM[8..11]=A0..A3.
  - Expected: A0 A1 A2 A3 then 188 payload bytes, back-to-back.
  - P_SYNC_OUT only on the 0x47 byte; exactly 188 RD_REQ[2] pulses.
- Round-robin: all 4 channels continuously full → service order 0,1,2,3,0; no idle cycles between packets.
- Enable mask: CH_EN=4'b1010, all full → only ch1 and ch3 served, alternating; RD_REQ[0] and RD_REQ[2] never assert.
- Backpressure: READY_IN toggled pseudo-randomly (50%) during a packet.
  - Expected: output sequence identical to the READY_IN=1 run; DATA_OUT held stable while stalled.
- Reset mid-packet: RST high at payload byte 100 → next cycle all outputs at reset values; after release, a fresh full packet from ch0 is emitted correctly.
- TS_SYNC_CHECK_EN: first payload byte 0x48 on 3 packets → three SYNC_ERR pulses, ERR_COUNT=3; byte 0x47 → no pulse.

Source files
------------

// File: rtl/ts_packet_mux.sv
// N-channel transport-stream packet mux: round-robin grant, header bytes from ROM, then payload.
// Optional sync-byte checker enabled by defining TS_SYNC_CHECK_EN.
module ts_packet_mux #(
    parameter int N_CH    = 4,
    parameter int PKT_LEN = 188,
    parameter int HDR_LEN = 4,
    parameter int HA_W    = 4
) (
    input  logic                SYS_CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     GOT_FULL_PACKET,
    input  logic [N_CH-1:0]     CH_EN,
    input  logic [8*N_CH-1:0]   DATA_IN_BUS,
    output logic [N_CH-1:0]     RD_REQ,
    output logic [HA_W-1:0]     HEADER_BYTE_ADDR,
    input  logic [7:0]          HEADER_BYTE,
    output logic [7:0]          DATA_OUT,
    output logic                D_VALID_OUT,
    input  logic                READY_IN,
    output logic                P_SYNC_OUT,
    output logic [1:0]          STATE_MON,
    output logic [3:0]          CUR_CH,
    output logic                SYNC_ERR,
    output logic [15:0]         ERR_COUNT
);

    localparam int MAXL = (HDR_LEN > PKT_LEN) ? HDR_LEN : PKT_LEN;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {CHECK = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2} state_t;

    typedef struct packed {
        logic       hdr;
        logic       sync;
        logic [3:0] ch;
    } rd_tag_t;

    typedef struct packed {
        logic       sync;
        logic [7:0] data;
    } ob_ent_t;

    state_t        state;
    logic [3:0]    rr_ptr;
    logic [3:0]    cur_ch;
    logic [CW-1:0] cnt;

    logic          vld_pipe;
    rd_tag_t       pipe_tag;
    ob_ent_t       ob [2];
    logic [1:0]    occ;
    ob_ent_t       land;

    logic [15:0]   cand;
    logic [4:0]    scan_idx;
    logic          grant_vld;
    logic [3:0]    grant_ch;

    logic          pop;
    logic [2:0]    post_occ;
    logic          credit;
    logic          in_hdr;
    logic          want;
    logic          rd_issue;
    logic [3:0]    iss_ch;
    logic [CW-1:0] iss_idx;
    logic          last_hdr;
    logic          last_pay;
    logic [127:0]  din_pad;

    assign cand = 16'(GOT_FULL_PACKET & CH_EN);

    // Scan from the highest offset down so the nearest candidate at/after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        scan_idx  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            scan_idx = 5'(rr_ptr) + 5'(k);
            if (scan_idx >= 5'(N_CH))
                scan_idx = scan_idx - 5'(N_CH);
            if (cand[scan_idx[3:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = scan_idx[3:0];
            end
        end
    end

    // Credit counts the slot freed by this cycle's pop, which is what sustains 1 byte/cycle.
    assign pop      = D_VALID_OUT && READY_IN;
    assign post_occ = 3'(occ) - 3'(pop) + 3'(vld_pipe);
    assign credit   = post_occ < 3'd2;

    // CHECK issues the first read of a granted packet itself, so packets abut without a bubble.
    assign in_hdr   = (state == HEADER) || ((state == CHECK) && (HDR_LEN > 0));
    assign iss_ch   = (state == CHECK) ? grant_ch : cur_ch;
    assign iss_idx  = (state == CHECK) ? '0 : cnt;
    assign want     = !RST && ((state == CHECK) ? grant_vld : 1'b1);
    assign rd_issue = want && credit;
    assign last_hdr = in_hdr && (iss_idx == CW'(HDR_LEN - 1));
    assign last_pay = !in_hdr && (iss_idx == CW'(PKT_LEN - 1));

    assign HEADER_BYTE_ADDR = HA_W'(iss_ch) * HA_W'(HDR_LEN) + HA_W'(iss_idx);

    for (genvar i = 0; i < N_CH; i++) begin : g_rd
        assign RD_REQ[i] = rd_issue && !in_hdr && (iss_ch == 4'(i));
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state    <= CHECK;
            rr_ptr   <= '0;
            cur_ch   <= '0;
            cnt      <= '0;
            vld_pipe <= 1'b0;
            pipe_tag <= '0;
        end else begin
            vld_pipe <= rd_issue;
            if (rd_issue)
                pipe_tag <= '{hdr: in_hdr, sync: (!in_hdr && (iss_idx == '0)), ch: iss_ch};
            if ((state == CHECK) && grant_vld)
                cur_ch <= grant_ch;
            if (rd_issue) begin
                if (last_pay) begin
                    state  <= CHECK;
                    rr_ptr <= (iss_ch == 4'(N_CH - 1)) ? 4'd0 : iss_ch + 4'd1;
                    cnt    <= '0;
                end else if (last_hdr) begin
                    state <= PAYLOAD;
                    cnt   <= '0;
                end else begin
                    state <= in_hdr ? HEADER : PAYLOAD;
                    cnt   <= iss_idx + CW'(1);
                end
            end else if ((state == CHECK) && grant_vld) begin
                state <= in_hdr ? HEADER : PAYLOAD;
                cnt   <= '0;
            end
        end
    end

    assign din_pad = 128'(DATA_IN_BUS);
    assign land    = '{sync: pipe_tag.sync,
                       data: (pipe_tag.hdr ? HEADER_BYTE : din_pad[{pipe_tag.ch, 3'b000} +: 8])};

    // Entry 0 is always the head; credit guarantees no push lands while both entries are full.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            occ   <= '0;
            ob[0] <= '0;
            ob[1] <= '0;
        end else begin
            case ({pop, vld_pipe})
                2'b10: begin
                    ob[0] <= ob[1];
                    occ   <= occ - 2'd1;
                end
                2'b01: begin
                    ob[occ[0]] <= land;
                    occ        <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ob[0] <= land;
                    end else begin
                        ob[0] <= ob[1];
                        ob[1] <= land;
                    end
                end
                default: ;
            endcase
        end
    end

    assign D_VALID_OUT = (occ != 2'd0);
    assign DATA_OUT    = ob[0].data;
    assign P_SYNC_OUT  = D_VALID_OUT && ob[0].sync;
    assign STATE_MON   = state;
    assign CUR_CH      = cur_ch;

`ifdef TS_SYNC_CHECK_EN
    logic [15:0] err_cnt;

    assign SYNC_ERR  = pop && P_SYNC_OUT && (DATA_OUT != 8'h47);
    assign ERR_COUNT = err_cnt;

    always_ff @(posedge SYS_CLK) begin
        if (RST)
            err_cnt <= '0;
        else if (SYNC_ERR && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign SYNC_ERR  = 1'b0;
    assign ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_ts_packet_mux.sv
// Directed bench for ts_packet_mux: FIFO/ROM models feed the mux, output bytes are logged and compared.
module tb_ts_packet_mux;

    localparam int N  = 4;
    localparam int PL = 188;
    localparam int HL = 4;
    localparam int PB = PL + HL;

`ifdef TS_SYNC_CHECK_EN
    localparam int EXP_ERR = 3;
`else
    localparam int EXP_ERR = 0;
`endif

    logic           SYS_CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   GOT_FULL_PACKET;
    logic [N-1:0]   CH_EN = 4'hF;
    logic [8*N-1:0] DATA_IN_BUS = '0;
    logic [N-1:0]   RD_REQ;
    logic [3:0]     HEADER_BYTE_ADDR;
    logic [7:0]     HEADER_BYTE = '0;
    logic [7:0]     DATA_OUT;
    logic           D_VALID_OUT;
    logic           READY_IN = 1'b1;
    logic           P_SYNC_OUT;
    logic [1:0]     STATE_MON;
    logic [3:0]     CUR_CH;
    logic           SYNC_ERR;
    logic [15:0]    ERR_COUNT;

    ts_packet_mux #(.N_CH(N), .PKT_LEN(PL), .HDR_LEN(HL), .HA_W(4)) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(GOT_FULL_PACKET), .CH_EN(CH_EN),
        .DATA_IN_BUS(DATA_IN_BUS), .RD_REQ(RD_REQ), .HEADER_BYTE_ADDR(HEADER_BYTE_ADDR),
        .HEADER_BYTE(HEADER_BYTE), .DATA_OUT(DATA_OUT), .D_VALID_OUT(D_VALID_OUT),
        .READY_IN(READY_IN), .P_SYNC_OUT(P_SYNC_OUT), .STATE_MON(STATE_MON), .CUR_CH(CUR_CH),
        .SYNC_ERR(SYNC_ERR), .ERR_COUNT(ERR_COUNT));

    always #5 SYS_CLK = ~SYS_CLK;

    int         vecs = 0;
    int         errs = 0;
    int         avail [N];
    int         rd_cnt [N];
    int         rdp [N];
    int         cyc = 0;
    int         sync_pulses = 0;
    logic       mdl_clr = 1'b0;
    logic [7:0] first_byte = 8'h47;
    logic [8:0] out_q [$];
    int         out_cyc [$];
    logic [8:0] exp_q [$];

    function automatic logic [7:0] rom_val(input int a);
        return 8'(8'h80 + (a / 4) * 16 + (a % 4));
    endfunction

    function automatic logic [7:0] fifo_byte(input int ch, input int n);
        int p, k;
        p = n / PL;
        k = n % PL;
        return (k == 0) ? first_byte : 8'(ch * 16 + p * 5 + k);
    endfunction

    always_comb begin
        GOT_FULL_PACKET = '0;
        for (int c = 0; c < N; c++)
            GOT_FULL_PACKET[c] = (rd_cnt[c] + PL <= avail[c] * PL);
    end

    // Upstream models: synchronous ROM and per-channel FIFOs with 1-cycle read latency.
    always @(posedge SYS_CLK) begin
        cyc <= cyc + 1;
        HEADER_BYTE <= rom_val(int'(HEADER_BYTE_ADDR));
        for (int c = 0; c < N; c++) begin
            if (mdl_clr) begin
                rd_cnt[c] <= 0;
                DATA_IN_BUS[8*c +: 8] <= 8'h00;
            end else if (RD_REQ[c]) begin
                DATA_IN_BUS[8*c +: 8] <= fifo_byte(c, rd_cnt[c]);
                rd_cnt[c] <= rd_cnt[c] + 1;
            end
        end
    end

    always @(negedge SYS_CLK) begin
        if (D_VALID_OUT && READY_IN) begin
            out_q.push_back({P_SYNC_OUT, DATA_OUT});
            out_cyc.push_back(cyc);
        end
        for (int c = 0; c < N; c++)
            if (RD_REQ[c]) rdp[c] <= rdp[c] + 1;
        if (SYNC_ERR) sync_pulses <= sync_pulses + 1;
    end

    task automatic do_reset();
        @(posedge SYS_CLK); #1;
        RST = 1'b1; mdl_clr = 1'b1; READY_IN = 1'b1; CH_EN = 4'hF; first_byte = 8'h47;
        for (int c = 0; c < N; c++) avail[c] = 0;
        repeat (2) @(posedge SYS_CLK);
        #1 RST = 1'b0; mdl_clr = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge SYS_CLK); #1;
            if (out_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_pkt(input int ch, input int p, input logic [7:0] fb);
        for (int i = 0; i < HL; i++) exp_q.push_back({1'b0, rom_val(ch * HL + i)});
        for (int k = 0; k < PL; k++)
            exp_q.push_back((k == 0) ? {1'b1, fb} : {1'b0, 8'(ch * 16 + p * 5 + k)});
    endtask

    task automatic test_reset();
        @(negedge SYS_CLK);
        vecs += 8;
        if (STATE_MON !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", STATE_MON); end
        if (CUR_CH !== 4'd0) begin errs++; $display("FAIL reset_cur_ch got %0d want 0", CUR_CH); end
        if (RD_REQ !== 4'h0) begin errs++; $display("FAIL reset_rd_req got %h want 0", RD_REQ); end
        if (D_VALID_OUT !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", D_VALID_OUT); end
        if (P_SYNC_OUT !== 1'b0) begin errs++; $display("FAIL reset_psync got %b want 0", P_SYNC_OUT); end
        if (DATA_OUT !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", DATA_OUT); end
        if (SYNC_ERR !== 1'b0) begin errs++; $display("FAIL reset_sync_err got %b want 0", SYNC_ERR); end
        if (ERR_COUNT !== 16'h0) begin errs++; $display("FAIL reset_err_count got %h want 0", ERR_COUNT); end
    endtask

    task automatic test_single_channel();
        int s, c0, rd_s [N];
        bit ok;
        logic [8:0] got;
        do_reset();
        s = out_q.size(); rd_s = rdp; exp_q.delete();
        push_pkt(2, 0, 8'h47);
        @(posedge SYS_CLK); #1;
        avail[2] = 1; c0 = cyc;
        repeat (20) @(negedge SYS_CLK);
        vecs++;
        if (CUR_CH !== 4'd2) begin errs++; $display("FAIL single_cur_ch got %0d want 2", CUR_CH); end
        wait_out(s + PB, 600, ok);
        repeat (4) @(negedge SYS_CLK);
        vecs++;
        if (!ok) begin errs++; $display("FAIL single_timeout got %0d bytes want %0d", out_q.size() - s, PB); end
        for (int i = 0; i < PB; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 9'h1ff;
            vecs++;
            if (got !== exp_q[i]) begin errs++; $display("FAIL single_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        vecs++;
        if (out_q.size() > s && out_cyc[s] !== c0 + 2) begin
            errs++; $display("FAIL single_latency got %0d want %0d", out_cyc[s] - c0, 2);
        end
        vecs++;
        if (out_q.size() >= s + PB && out_cyc[s + PB - 1] - out_cyc[s] !== PB - 1) begin
            errs++; $display("FAIL single_contig got span %0d want %0d", out_cyc[s + PB - 1] - out_cyc[s], PB - 1);
        end
        vecs += 2;
        if (rdp[2] - rd_s[2] !== PL) begin errs++; $display("FAIL single_rd2 got %0d want %0d", rdp[2] - rd_s[2], PL); end
        if ((rdp[0] - rd_s[0]) + (rdp[1] - rd_s[1]) + (rdp[3] - rd_s[3]) !== 0) begin
            errs++; $display("FAIL single_rd_other got nonzero want 0");
        end
    endtask

    task automatic test_round_robin();
        int s, gaps;
        bit ok;
        logic [8:0] got;
        do_reset();
        s = out_q.size(); exp_q.delete();
        push_pkt(0, 0, 8'h47); push_pkt(1, 0, 8'h47); push_pkt(2, 0, 8'h47);
        push_pkt(3, 0, 8'h47); push_pkt(0, 1, 8'h47);
        @(posedge SYS_CLK); #1;
        for (int c = 0; c < N; c++) avail[c] = 100;
        wait_out(s + 5 * PB, 1500, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL rr_timeout got %0d bytes want %0d", out_q.size() - s, 5 * PB); end
        for (int i = 0; i < 5 * PB; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 9'h1ff;
            vecs++;
            if (got !== exp_q[i]) begin errs++; $display("FAIL rr_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        gaps = 0;
        for (int i = 1; i < 5 * PB && s + i < out_q.size(); i++)
            if (out_cyc[s + i] != out_cyc[s + i - 1] + 1) gaps++;
        vecs++;
        if (gaps !== 0) begin errs++; $display("FAIL rr_idle_cycles got %0d want 0", gaps); end
    endtask

    task automatic test_enable_mask();
        int s, rd_s [N];
        bit ok;
        logic [8:0] got;
        do_reset();
        s = out_q.size(); rd_s = rdp; exp_q.delete();
        push_pkt(1, 0, 8'h47); push_pkt(3, 0, 8'h47); push_pkt(1, 1, 8'h47); push_pkt(3, 1, 8'h47);
        @(posedge SYS_CLK); #1;
        CH_EN = 4'b1010;
        for (int c = 0; c < N; c++) avail[c] = 100;
        wait_out(s + 4 * PB, 1200, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL mask_timeout got %0d bytes want %0d", out_q.size() - s, 4 * PB); end
        for (int i = 0; i < 4 * PB; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 9'h1ff;
            vecs++;
            if (got !== exp_q[i]) begin errs++; $display("FAIL mask_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        vecs++;
        if ((rdp[0] - rd_s[0]) + (rdp[2] - rd_s[2]) !== 0) begin
            errs++; $display("FAIL mask_rd_0_2 got %0d want 0", (rdp[0] - rd_s[0]) + (rdp[2] - rd_s[2]));
        end
        // All channels full but none enabled: the arbiter must sit in CHECK.
        do_reset();
        rd_s = rdp;
        @(posedge SYS_CLK); #1;
        CH_EN = 4'h0;
        for (int c = 0; c < N; c++) avail[c] = 100;
        repeat (20) @(negedge SYS_CLK);
        vecs += 2;
        if (STATE_MON !== 2'd0) begin errs++; $display("FAIL mask_none_state got %0d want 0", STATE_MON); end
        if ((rdp[0] - rd_s[0]) + (rdp[1] - rd_s[1]) + (rdp[2] - rd_s[2]) + (rdp[3] - rd_s[3]) !== 0) begin
            errs++; $display("FAIL mask_none_rd got nonzero want 0");
        end
    endtask

    task automatic test_backpressure();
        int s, rd_s [N], stalls;
        bit stalled, done;
        logic [7:0] held;
        logic [8:0] got;
        do_reset();
        s = out_q.size(); rd_s = rdp; exp_q.delete();
        push_pkt(1, 0, 8'h47);
        @(posedge SYS_CLK); #1;
        avail[1] = 1;
        stalled = 1'b0; held = 8'h00; stalls = 0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge SYS_CLK); #1;
            READY_IN = 1'($urandom_range(0, 1));
            @(negedge SYS_CLK);
            if (stalled) begin
                vecs++;
                if (DATA_OUT !== held || D_VALID_OUT !== 1'b1) begin
                    errs++; $display("FAIL bp_hold got %h/%b want %h/1", DATA_OUT, D_VALID_OUT, held);
                end
            end
            stalled = D_VALID_OUT && !READY_IN;
            if (stalled) stalls++;
            held = DATA_OUT;
            #1 done = (out_q.size() >= s + PB);
        end
        READY_IN = 1'b1;
        repeat (4) @(negedge SYS_CLK);
        vecs += 3;
        if (!done) begin errs++; $display("FAIL bp_timeout got %0d bytes want %0d", out_q.size() - s, PB); end
        if (stalls == 0) begin errs++; $display("FAIL bp_no_stall got 0 stall cycles want >0"); end
        if (rdp[1] - rd_s[1] !== PL) begin errs++; $display("FAIL bp_rd1 got %0d want %0d", rdp[1] - rd_s[1], PL); end
        vecs++;
        if (out_q.size() !== s + PB) begin errs++; $display("FAIL bp_count got %0d want %0d", out_q.size() - s, PB); end
        for (int i = 0; i < PB; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 9'h1ff;
            vecs++;
            if (got !== exp_q[i]) begin errs++; $display("FAIL bp_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int s;
        bit ok;
        logic [8:0] got;
        do_reset();
        s = out_q.size();
        @(posedge SYS_CLK); #1;
        avail[0] = 1;
        wait_out(s + HL + 100, 600, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL rst_mid_timeout got %0d bytes want %0d", out_q.size() - s, HL + 100); end
        RST = 1'b1; mdl_clr = 1'b1;
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        vecs += 6;
        if (STATE_MON !== 2'd0) begin errs++; $display("FAIL rst_mid_state got %0d want 0", STATE_MON); end
        if (CUR_CH !== 4'd0) begin errs++; $display("FAIL rst_mid_cur_ch got %0d want 0", CUR_CH); end
        if (RD_REQ !== 4'h0) begin errs++; $display("FAIL rst_mid_rd_req got %h want 0", RD_REQ); end
        if (D_VALID_OUT !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got %b want 0", D_VALID_OUT); end
        if (P_SYNC_OUT !== 1'b0) begin errs++; $display("FAIL rst_mid_psync got %b want 0", P_SYNC_OUT); end
        if (DATA_OUT !== 8'h00) begin errs++; $display("FAIL rst_mid_data got %h want 00", DATA_OUT); end
        #1 RST = 1'b0; mdl_clr = 1'b0;
        s = out_q.size(); exp_q.delete();
        push_pkt(0, 0, 8'h47);
        wait_out(s + PB, 600, ok);
        repeat (4) @(negedge SYS_CLK);
        vecs += 2;
        if (!ok) begin errs++; $display("FAIL rst_fresh_timeout got %0d bytes want %0d", out_q.size() - s, PB); end
        if (out_q.size() !== s + PB) begin errs++; $display("FAIL rst_fresh_count got %0d want %0d", out_q.size() - s, PB); end
        for (int i = 0; i < PB; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 9'h1ff;
            vecs++;
            if (got !== exp_q[i]) begin errs++; $display("FAIL rst_fresh_byte[%0d] got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_sync_check();
        int s, p0;
        bit ok;
        logic [8:0] got;
        do_reset();
        s = out_q.size(); p0 = sync_pulses;
        @(posedge SYS_CLK); #1;
        first_byte = 8'h48; avail[0] = 3;
        wait_out(s + 3 * PB, 1000, ok);
        repeat (4) @(negedge SYS_CLK);
        vecs++;
        if (!ok) begin errs++; $display("FAIL sync_timeout got %0d bytes want %0d", out_q.size() - s, 3 * PB); end
        for (int p = 0; p < 3; p++) begin
            got = (s + p * PB + HL < out_q.size()) ? out_q[s + p * PB + HL] : 9'h1ff;
            vecs++;
            if (got !== 9'h148) begin errs++; $display("FAIL sync_fwd[%0d] got %h want 148", p, got); end
        end
        vecs += 2;
        if (sync_pulses - p0 !== EXP_ERR) begin errs++; $display("FAIL sync_pulses got %0d want %0d", sync_pulses - p0, EXP_ERR); end
        if (ERR_COUNT !== 16'(EXP_ERR)) begin errs++; $display("FAIL sync_err_count got %0d want %0d", ERR_COUNT, EXP_ERR); end
        first_byte = 8'h47; avail[0] = 4;
        wait_out(s + 4 * PB, 400, ok);
        repeat (4) @(negedge SYS_CLK);
        vecs += 3;
        if (!ok) begin errs++; $display("FAIL sync_good_timeout got %0d bytes want %0d", out_q.size() - s, 4 * PB); end
        if (sync_pulses - p0 !== EXP_ERR) begin errs++; $display("FAIL sync_good_pulses got %0d want %0d", sync_pulses - p0, EXP_ERR); end
        if (ERR_COUNT !== 16'(EXP_ERR)) begin errs++; $display("FAIL sync_good_count got %0d want %0d", ERR_COUNT, EXP_ERR); end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            avail[c] = 0;
            rdp[c] = 0;
        end
        mdl_clr = 1'b1;
        repeat (3) @(posedge SYS_CLK);
        #1 RST = 1'b0; mdl_clr = 1'b0;
        RST = 1'b1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_enable_mask();
        test_backpressure();
        test_reset_mid_packet();
        test_sync_check();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
